// File: rtl/gen_sequencer.sv
// Generation sequencer: streams one generation of reads out of the double buffer,
// collects the compute core's results into the write side, then swaps on vsync.
module gen_sequencer #(
    parameter int NUM_WORDS    = 1024,
    parameter int READ_LATENCY = 2,
    parameter int LOG_MAX_ADDR = 10,
    parameter int WORD_SIZE    = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    run_in,
    input  logic                    step_in,
    input  logic                    buf_ready_in,
    input  logic                    vsync_in,
    input  logic                    res_valid_in,
    input  logic [WORD_SIZE-1:0]    res_data_in,
    output logic [LOG_MAX_ADDR-1:0] logic_addr_r,
    output logic                    rd_valid_out,
    output logic [LOG_MAX_ADDR-1:0] logic_addr_w,
    output logic [WORD_SIZE-1:0]    logic_data_w,
    output logic                    logic_wr_en,
    output logic                    swap_out,
    output logic                    busy_out,
    output logic [15:0]             gen_count_out,
    output logic                    overflow_out
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_VSYNC,
        SWAP
    } state_t;

    // The write counter needs one extra bit so it can sit at NUM_WORDS ("full").
    localparam int                    CW      = LOG_MAX_ADDR + 1;
    localparam logic [CW-1:0]           WR_FULL = CW'(NUM_WORDS);
    localparam logic [LOG_MAX_ADDR-1:0] RD_LAST = LOG_MAX_ADDR'(NUM_WORDS - 1);

    state_t                    state_q, state_d;
    logic [LOG_MAX_ADDR-1:0]   rdAddr_q;
    logic [CW-1:0]             wrCnt_q;
    logic [READ_LATENCY-1:0]   rdValidSr_q;
    logic                      swap_q;
    logic                      busy_q;
    logic [15:0]               genCnt_q;
    logic                      overflow_q;
    logic                      wrAccept;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (buf_ready_in && (run_in || step_in)) state_d = READ;
            READ:       if (rdAddr_q == RD_LAST) state_d = DRAIN;
            DRAIN:      if (wrCnt_q == WR_FULL) state_d = WAIT_VSYNC;
            WAIT_VSYNC: if (vsync_in) state_d = SWAP;
            SWAP:       state_d = (run_in && buf_ready_in) ? READ : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Results are only taken while a generation is collecting and the buffer is not yet full.
    assign wrAccept     = ((state_q == READ) || (state_q == DRAIN)) && (wrCnt_q != WR_FULL);
    assign logic_wr_en  = res_valid_in && wrAccept;
    assign logic_data_w = res_data_in;
    assign logic_addr_w = wrCnt_q[LOG_MAX_ADDR-1:0];
    assign logic_addr_r = rdAddr_q;
    assign rd_valid_out = rdValidSr_q[READ_LATENCY-1];
    assign swap_out      = swap_q;
    assign busy_out      = busy_q;
    assign gen_count_out = genCnt_q;
    assign overflow_out  = overflow_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            rdAddr_q    <= '0;
            wrCnt_q     <= '0;
            rdValidSr_q <= '0;
            swap_q      <= 1'b0;
            busy_q      <= 1'b0;
            genCnt_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            swap_q  <= (state_d == SWAP);
            busy_q  <= (state_d != IDLE);

            if ((state_q == READ) && (rdAddr_q != RD_LAST)) begin
                rdAddr_q <= rdAddr_q + LOG_MAX_ADDR'(1);
            end else if (state_q == SWAP) begin
                rdAddr_q <= '0;
            end

            if (state_q == SWAP) begin
                wrCnt_q <= '0;
            end else if (logic_wr_en) begin
                wrCnt_q <= wrCnt_q + CW'(1);
            end

            if (state_q == SWAP) begin
                genCnt_q <= genCnt_q + 16'd1;
            end

            if (res_valid_in && !wrAccept) begin
                overflow_q <= 1'b1;
            end

            // Read data returns READ_LATENCY cycles after its address was issued.
            rdValidSr_q[0] <= (state_q == READ);
            for (int i = 1; i < READ_LATENCY; i++) begin
                rdValidSr_q[i] <= rdValidSr_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_gen_sequencer.sv
// Self-checking bench for gen_sequencer with NUM_WORDS=4, READ_LATENCY=2; expected values
// come from a generation-level timeline model driven by randomized results and vsync timing.
module tb_gen_sequencer;

    localparam int NW  = 4;
    localparam int LAT = 2;
    localparam int AW  = 4;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          step;
    logic          bufReady;
    logic          vsync;
    logic          resValid;
    logic [DW-1:0] resData;

    logic [AW-1:0] addrR;
    logic          rdValid;
    logic [AW-1:0] addrW;
    logic [DW-1:0] dataW;
    logic          wrEn;
    logic          swap;
    logic          busy;
    logic [15:0]   genCount;
    logic          overflow;

    int checkCount  = 0;
    int failCount   = 0;
    int modelGen    = 0;
    bit overflowExp = 1'b0;

    always #5 clk = ~clk;

    gen_sequencer #(
        .NUM_WORDS   (NW),
        .READ_LATENCY(LAT),
        .LOG_MAX_ADDR(AW),
        .WORD_SIZE   (DW)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .run_in       (run),
        .step_in      (step),
        .buf_ready_in (bufReady),
        .vsync_in     (vsync),
        .res_valid_in (resValid),
        .res_data_in  (resData),
        .logic_addr_r (addrR),
        .rd_valid_out (rdValid),
        .logic_addr_w (addrW),
        .logic_data_w (dataW),
        .logic_wr_en  (wrEn),
        .swap_out     (swap),
        .busy_out     (busy),
        .gen_count_out(genCount),
        .overflow_out (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input logic [DW-1:0] data, input bit vs);
        resValid = valid;
        resData  = data;
        vsync    = vsync_q(vs);
    endtask

    function automatic logic vsync_q(input bit vs);
        return logic'(vs);
    endfunction

    task automatic checkRegs(input string where, input bit busyExp, input bit swapExp);
        checkOutput({where, " busy"}, 32'(busy), 32'(busyExp));
        checkOutput({where, " swap"}, 32'(swap), 32'(swapExp));
        checkOutput({where, " gen_count"}, 32'(genCount), 32'(modelGen % 65536));
        checkOutput({where, " overflow"}, 32'(overflow), 32'(overflowExp));
    endtask

    // One generation: the edge following the call enters READ. Returns during the SWAP cycle.
    task automatic runGeneration(input bit earlyVsync, input bit runDuring, input bit runAfter,
                                 input bit extraWrite, input int vsyncDelay);
        int c = 0;
        int wcount = 0;
        bit valid;
        do begin
            tick();
            c++;
            if (c == 1) step = 1'b0;
            if (c == 3) run = runDuring;
            checkRegs("gen", 1'b1, 1'b0);
            if (c <= NW) checkOutput("addr_r issue", 32'(addrR), 32'(c - 1));
            else         checkOutput("addr_r hold", 32'(addrR), 32'(NW - 1));
            checkOutput("rd_valid", 32'(rdValid), 32'((c > LAT) && (c <= NW + LAT)));
            valid = (wcount < NW) && (($urandom % 100 < 60) || (c > 10));
            applyStimulus(valid, DW'($urandom), earlyVsync && (c == 2));
            #1;
            checkOutput("wr_en", 32'(wrEn), 32'(valid));
            if (valid) begin
                checkOutput("addr_w", 32'(addrW), 32'(wcount));
                checkOutput("data_w", 32'(dataW), 32'(resData));
                wcount++;
            end
        end while (!((c >= NW + LAT) && (wcount == NW)));

        if (extraWrite) begin
            tick();
            checkRegs("extra", 1'b1, 1'b0);
            applyStimulus(1'b1, DW'($urandom), 1'b0);
            #1;
            checkOutput("dropped wr_en", 32'(wrEn), 32'(0));
            overflowExp = 1'b1;
        end

        for (int i = 0; i < 2 + vsyncDelay; i++) begin
            tick();
            checkRegs("wait vsync", 1'b1, 1'b0);
            checkOutput("addr_r wait", 32'(addrR), 32'(NW - 1));
            checkOutput("rd_valid wait", 32'(rdValid), 32'(0));
            applyStimulus(1'b0, '0, i == 1 + vsyncDelay);
        end

        tick();
        checkRegs("swap cycle", 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        run = runAfter;
        modelGen++;
    endtask

    task automatic endIdle(input string where);
        tick();
        checkRegs(where, 1'b0, 1'b0);
        checkOutput({where, " rd_valid"}, 32'(rdValid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        step = 1'b0;
        bufReady = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        tick();
        checkRegs("reset", 1'b0, 1'b0);
        checkOutput("reset addr_r", 32'(addrR), 32'(0));
        checkOutput("reset rd_valid", 32'(rdValid), 32'(0));
        checkOutput("reset wr_en", 32'(wrEn), 32'(0));
        rst = 1'b0;

        // Start requests must be ignored while the buffer is not ready.
        step = 1'b1;
        tick();
        step = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkRegs("not ready", 1'b0, 1'b0);
        end
        run = 1'b0;
        endIdle("not ready end");

        // Single stepped generation; a vsync seen during READ must not be remembered.
        bufReady = 1'b1;
        step = 1'b1;
        runGeneration(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(3, 8)));
        endIdle("after step");

        // Back-to-back generations while run is held.
        run = 1'b1;
        runGeneration(1'b0, 1'b1, 1'b1, 1'b0, int'($urandom_range(0, 6)));
        runGeneration(1'b1, 1'b1, 1'b1, 1'b0, int'($urandom_range(0, 6)));
        runGeneration(1'b0, 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 6)));
        endIdle("after run");

        // Dropping run mid-generation completes it, then returns to IDLE.
        run = 1'b1;
        runGeneration(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 4)));
        endIdle("after drop");

        // Randomized stepped generations.
        for (int g = 0; g < 3; g++) begin
            step = 1'b1;
            runGeneration(1'($urandom % 2), 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 5)));
            endIdle("random step");
        end

        // Fifth result in one generation is dropped and latches overflow.
        step = 1'b1;
        runGeneration(1'b0, 1'b0, 1'b0, 1'b1, int'($urandom_range(0, 3)));
        endIdle("after overflow");
        endIdle("overflow sticky");

        // Reset during DRAIN abandons the generation.
        step = 1'b1;
        for (int c = 1; c <= NW + 1; c++) begin
            tick();
            if (c == 1) step = 1'b0;
            checkRegs("pre reset", 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        overflowExp = 1'b0;
        modelGen = 0;
        checkRegs("mid reset", 1'b0, 1'b0);
        checkOutput("mid reset addr_r", 32'(addrR), 32'(0));
        checkOutput("mid reset rd_valid", 32'(rdValid), 32'(0));
        rst = 1'b0;
        endIdle("post reset");

        step = 1'b1;
        runGeneration(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 3)));
        endIdle("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/gen_sequencer.md
GEN_SEQUENCER -- requirements
Module: gen_sequencer

Interface
REQ-001 Parameter NUM_WORDS, default 1024, SHALL set the words per generation; legal range 2..2**LOG_MAX_ADDR.
REQ-002 Parameter READ_LATENCY, default 2, SHALL set the cycles from a logic_addr_r issue to its data at the double buffer's logic_data_r.
REQ-003 One clock, clk_in; reset rst_in, synchronous, active-high.
REQ-004 clk_in  input  1  system clock; all state on its rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 run_in  input  1  level; when 1, generations run back-to-back.
REQ-007 step_in  input  1  one-cycle pulse; runs exactly one generation from IDLE.
REQ-008 buf_ready_in  input  1  double buffer ready; IDLE SHALL NOT be left while 0.
REQ-009 vsync_in  input  1  one-cycle frame-boundary pulse from the render side.
REQ-010 res_valid_in  input  1  the compute core presents a result word.
REQ-011 res_data_in  input  WORD_SIZE  result word.
REQ-012 logic_addr_r  output  LOG_MAX_ADDR  read address to the double buffer.
REQ-013 rd_valid_out  output  1  high exactly in cycles where logic_data_r holds a word requested by this block.
REQ-014 logic_addr_w / logic_data_w / logic_wr_en  output  LOG_MAX_ADDR / WORD_SIZE / 1  write port to the double buffer.
REQ-015 swap_out  output  1  one-cycle buffer swap pulse.
REQ-016 busy_out  output  1  high in any state other than IDLE.
REQ-017 gen_count_out  output  16  count of completed generations.
REQ-018 overflow_out  output  1  sticky error flag.

Function
REQ-019 FSM states SHALL be IDLE, READ, DRAIN, WAIT_VSYNC and SWAP.
REQ-020 IDLE->READ SHALL occur when buf_ready_in=1 and (run_in=1 or step_in=1); step_in has no effect outside IDLE.
REQ-021 READ SHALL issue logic_addr_r = 0..NUM_WORDS-1, one per cycle, with no gaps, then go to DRAIN.
REQ-022 rd_valid_out SHALL be the issue strobe delayed by READ_LATENCY cycles through a shift register.
REQ-023 logic_wr_en SHALL equal res_valid_in combinationally, gated off when the write counter equals NUM_WORDS.
REQ-024 logic_data_w SHALL equal res_data_in.
REQ-025 logic_addr_w SHALL be the write counter; it increments on each accepted write.
REQ-026 res_valid_in with the write counter at NUM_WORDS, or in IDLE/WAIT_VSYNC/SWAP, SHALL be dropped and SHALL set overflow_out.
REQ-027 DRAIN->WAIT_VSYNC SHALL occur in the cycle after the write counter reaches NUM_WORDS.
REQ-028 WAIT_VSYNC->SWAP SHALL occur on vsync_in=1; vsync_in in other states SHALL be ignored (not latched).
REQ-029 SWAP SHALL last one cycle; swap_out=1 only in SWAP; gen_count_out increments (wraps at 16 bits); the read and write counters clear.
REQ-030 SWAP->READ SHALL occur if run_in=1 and buf_ready_in=1, else SWAP->IDLE.
REQ-031 Dropping run_in mid-generation SHALL NOT abort it; the generation completes through SWAP and then returns to IDLE.
REQ-032 logic_addr_r SHALL hold its last value outside READ; addresses SHALL never exceed NUM_WORDS-1.

Reset
REQ-033 On rst_in the FSM SHALL enter IDLE; read/write counters, rd_valid_out shift register, swap_out, logic_wr_en gating, gen_count_out and overflow_out SHALL clear to 0, with logic_addr_r=0.
REQ-034 Reset mid-generation SHALL abandon it immediately, with no swap_out, and the next cycle SHALL show IDLE outputs.

Verification (NUM_WORDS=4, READ_LATENCY=2)
REQ-035 step_in pulse, buf_ready_in=1 -> logic_addr_r 0,1,2,3 on consecutive cycles; rd_valid_out high 4 cycles starting 2 cycles after the first issue.
REQ-036 Core returns 4 results (values A..D) -> writes to addresses 0..3 with data A..D; vsync_in -> single swap_out pulse next cycle; gen_count_out=1; back to IDLE.
REQ-037 run_in=1 held, vsync every 20 cycles -> continuous generations; exactly one swap per generation; gen_count_out=3 after 3 vsyncs seen in WAIT_VSYNC.
REQ-038 vsync_in during READ only, then none -> remains in WAIT_VSYNC with no swap_out until the next vsync_in.
REQ-039 5th res_valid_in in one generation -> no write, overflow_out=1 and held until rst_in.
REQ-040 rst_in asserted during DRAIN -> IDLE next cycle; gen_count_out=0; no swap_out; and a subsequent step_in restarts at address 0.
